// File: rtl/grid_column_sequencer.sv
// Emits the NCOLS evenly spaced x positions between two marker positions, one per
// valid/ready beat, using a single accumulator instead of per-column multiply/divide.
module grid_column_sequencer #(
    parameter int WIDTH     = 10,
    parameter int COLS_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     first_x,
    input  logic [WIDTH-1:0]     sec_x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     x_out,
    output logic [COLS_LOG2-1:0] col_idx,
    output logic                 last,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int AW = WIDTH + COLS_LOG2;
    localparam logic [COLS_LOG2-1:0] K_LAST = '1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     base_q;
    logic [WIDTH-1:0]     diff_q;
    logic [WIDTH-1:0]     x_q;
    logic [AW-1:0]        acc_q;
    logic [COLS_LOG2-1:0] k_q;
    logic                 valid_q;
    logic                 last_q;
    logic                 done_q;
    logic                 err_q;

    logic [AW-1:0]        acc_d;
    logic [COLS_LOG2-1:0] k_d;
    logic                 hs;

    always_comb begin
        hs    = valid_q && out_ready;
        acc_d = acc_q + AW'(diff_q);
        k_d   = k_q + COLS_LOG2'(1);
    end

    // Outputs for beat k+1 are computed from acc_d so they are registered on the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            diff_q  <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (sec_x >= first_x) begin
                            base_q  <= first_x;
                            diff_q  <= sec_x - first_x;
                            acc_q   <= '0;
                            k_q     <= '0;
                            x_q     <= first_x;
                            last_q  <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (k_q == K_LAST) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            acc_q  <= acc_d;
                            k_q    <= k_d;
                            x_q    <= base_q + acc_d[AW-1:COLS_LOG2];
                            last_q <= (k_d == K_LAST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = valid_q;
    assign x_out     = x_q;
    assign col_idx   = k_q;
    assign last      = last_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_grid_column_sequencer.sv
// Scoreboard bench for grid_column_sequencer: stimulus pushes expected beats, a negedge
// monitor pops and compares on every handshake and checks stall stability and done timing.
module tb_grid_column_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] first_x = '0;
    logic [9:0] sec_x = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] x_out;
    logic [4:0] col_idx;
    logic       last;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct packed {
        logic [9:0] x;
        logic [4:0] idx;
        logic       lst;
    } beat_t;

    beat_t sb[$];
    int unsigned asserts = 0;
    int unsigned failures = 0;
    logic rand_mode = 1'b0;

    grid_column_sequencer #(.WIDTH(10), .COLS_LOG2(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_x(first_x), .sec_x(sec_x),
        .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .col_idx(col_idx),
        .last(last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor
    logic       prev_last_hs = 1'b0;
    logic       prev_stall = 1'b0;
    logic [9:0] held_x;
    logic [4:0] held_idx;
    logic       held_last;
    beat_t      got;
    beat_t      exp_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_last_hs = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            asserts++;
            if (done !== prev_last_hs) begin
                failures++;
                $display("FAIL done_timing: done=%b required %b at %0t", done, prev_last_hs, $time);
            end
            if (prev_stall) begin
                asserts++;
                if (out_valid !== 1'b1 || x_out !== held_x || col_idx !== held_idx || last !== held_last) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%b x=%0d idx=%0d last=%b required valid=1 x=%0d idx=%0d last=%b",
                             out_valid, x_out, col_idx, last, held_x, held_idx, held_last);
                end
            end
            prev_last_hs = 1'b0;
            if (out_valid && out_ready) begin
                got = '{x: x_out, idx: col_idx, lst: last};
                asserts++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: x=%0d idx=%0d last=%b required no beat", x_out, col_idx, last);
                end else begin
                    exp_b = sb.pop_front();
                    if (got !== exp_b) begin
                        failures++;
                        $display("FAIL beat: x=%0d idx=%0d last=%b required x=%0d idx=%0d last=%b",
                                 got.x, got.idx, got.lst, exp_b.x, exp_b.idx, exp_b.lst);
                    end
                end
                prev_last_hs = last;
            end
            prev_stall = out_valid && !out_ready;
            held_x     = x_out;
            held_idx   = col_idx;
            held_last  = last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ok, input string info);
        asserts++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, info);
        end
    endtask

    task automatic push_beat(input int unsigned x, input int unsigned k);
        sb.push_back('{x: 10'(x), idx: 5'(k), lst: (k == 31)});
    endtask

    task automatic issue_start(input int unsigned f, input int unsigned s);
        first_x = 10'(f);
        sec_x   = 10'(s);
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        logic got_done = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            step();
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        check({name, "_done"}, got_done, $sformatf("done not seen within %0d cycles", budget));
        check({name, "_drained"}, sb.size() == 0, $sformatf("%0d beats outstanding, required 0", sb.size()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        check("reset_state",
              {out_valid, busy, done, err, last, x_out, col_idx} == '0,
              $sformatf("valid=%b busy=%b done=%b err=%b last=%b x=%0d idx=%0d required all 0",
                        out_valid, busy, done, err, last, x_out, col_idx));
        rst_n = 1'b1;
        step();

        // 100..420: step 10 per column
        for (int unsigned k = 0; k < 32; k++) push_beat(100 + 10 * k, k);
        issue_start(100, 420);
        check("first_beat", out_valid === 1'b1 && busy === 1'b1 && x_out === 10'd100 && col_idx === 5'd0,
              $sformatf("valid=%b busy=%b x=%0d idx=%0d required 1 1 100 0", out_valid, busy, x_out, col_idx));
        wait_done("seq_100_420", 40);

        // start in the done cycle; 0..31 exercises floor division (k -> k-1)
        for (int unsigned k = 0; k < 32; k++) push_beat((k == 0) ? 0 : k - 1, k);
        issue_start(0, 31);
        check("start_on_done", out_valid === 1'b1 && col_idx === 5'd0 && x_out === 10'd0,
              $sformatf("valid=%b idx=%0d x=%0d required 1 0 0", out_valid, col_idx, x_out));
        wait_done("seq_0_31", 40);

        // back-pressure
        rand_mode = 1'b1;
        for (int unsigned k = 0; k < 32; k++) push_beat(100 + 10 * k, k);
        issue_start(100, 420);
        wait_done("seq_stall", 400);
        rand_mode = 1'b0;
        step();

        // reversed markers
        issue_start(500, 200);
        check("err_pulse", err === 1'b1 && out_valid === 1'b0 && busy === 1'b0,
              $sformatf("err=%b valid=%b busy=%b required 1 0 0", err, out_valid, busy));
        step();
        check("err_clear", err === 1'b0 && out_valid === 1'b0 && busy === 1'b0,
              $sformatf("err=%b valid=%b busy=%b required 0 0 0", err, out_valid, busy));

        // equal markers
        for (int unsigned k = 0; k < 32; k++) push_beat(77, k);
        issue_start(77, 77);
        wait_done("seq_equal", 40);

        // start during RUN and marker changes are ignored
        for (int unsigned k = 0; k < 32; k++) push_beat(100 + 10 * k, k);
        issue_start(100, 420);
        for (int unsigned i = 0; i < 5; i++) step();
        check("at_k5", col_idx === 5'd5, $sformatf("idx=%0d required 5", col_idx));
        issue_start(300, 900);
        first_x = 10'd1;
        sec_x   = 10'd2;
        wait_done("seq_ignore_start", 40);

        // reset mid-run at k=12
        for (int unsigned k = 0; k < 32; k++) push_beat(200 + k, k);
        issue_start(200, 232);
        for (int unsigned i = 0; i < 12; i++) step();
        check("at_k12", col_idx === 5'd12 && x_out === 10'd212,
              $sformatf("idx=%0d x=%0d required 12 212", col_idx, x_out));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", out_valid === 1'b0 && busy === 1'b0 && col_idx === 5'd0 && done === 1'b0,
              $sformatf("valid=%b busy=%b idx=%0d done=%b required 0 0 0 0", out_valid, busy, col_idx, done));
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        check("no_done_after_reset", done === 1'b0 && out_valid === 1'b0,
              $sformatf("done=%b valid=%b required 0 0", done, out_valid));

        for (int unsigned k = 0; k < 32; k++) push_beat(40 + k, k);
        issue_start(40, 72);
        check("fresh_start", col_idx === 5'd0 && x_out === 10'd40 && out_valid === 1'b1,
              $sformatf("idx=%0d x=%0d valid=%b required 0 40 1", col_idx, x_out, out_valid));
        wait_done("seq_after_reset", 40);

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
